// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: RAM handshake state, machine word, arbiter FSM state.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Status reported by the unified RAM each cycle.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Which requester currently owns the RAM port.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported unified RAM between instruction fetch and data access.
// Latency: registered grant, so >= 2 cycles per access (request cycle + ACCESS cycle).
// Backpressure: iwait/dwait stay high until the RAM completes the granted access.
//
// Ports:
//   CLK, RST                         clock, synchronous active-high reset
//   iREN, iaddr / iload, iwait       instruction requester
//   dREN, dWEN, daddr, dstore /
//   dload, dwait                     data requester
//   ramREN, ramWEN, ramaddr,
//   ramstore / ramload, ramstate     RAM port
//   mem_err                          sticky, set when the retry budget is exhausted
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int MAX_DSTREAK = 4,
    parameter int MAX_RETRY   = 3
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output word_t     iload,
    output logic      iwait,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output word_t     dload,
    output logic      dwait,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      mem_err
);

    localparam int STREAK_W = $clog2(MAX_DSTREAK + 1);
    localparam int RETRY_W  = $clog2(MAX_RETRY + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);
    localparam logic [RETRY_W-1:0]  RETRY_MAX  = RETRY_W'(MAX_RETRY);

    arb_state_t          state_q,   state_d;
    logic [STREAK_W-1:0] streak_q,  streak_d;
    logic [RETRY_W-1:0]  retry_q,   retry_d;
    logic                mem_err_q, mem_err_d;

    logic dreq;
    logic exhaust;
    logic ram_done;
    logic i_done;
    logic d_done;

    assign dreq = dREN | dWEN;

    // An ERROR with the retry budget spent is treated as a (data-less) completion.
    assign exhaust  = (ramstate == ERROR) && (retry_q == RETRY_MAX);
    assign ram_done = (ramstate == ACCESS) || exhaust;
    assign i_done   = (state_q == IGRANT) && iREN && ram_done;
    assign d_done   = (state_q == DGRANT) && dreq && ram_done;

    assign iwait   = iREN & ~i_done;
    assign dwait   = dreq & ~d_done;
    assign iload   = ramload;
    assign dload   = ramload;
    assign mem_err = mem_err_q;

    always_comb begin
        state_d   = state_q;
        streak_d  = streak_q;
        retry_d   = retry_q;
        mem_err_d = mem_err_q;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;

        case (state_q)
            IDLE: begin
                // Data wins unless it has starved a waiting fetch for MAX_DSTREAK grants.
                if (dreq && ((streak_q < STREAK_MAX) || !iREN)) begin
                    state_d = DGRANT;
                end else if (iREN) begin
                    state_d = IGRANT;
                end
            end

            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (!iREN) begin
                    // Pipeline flush: drop the fetch without completing it.
                    state_d = IDLE;
                    retry_d = '0;
                end else if (ram_done) begin
                    state_d  = IDLE;
                    retry_d  = '0;
                    streak_d = '0;
                    if (exhaust) begin
                        mem_err_d = 1'b1;
                    end
                end else if (ramstate == ERROR) begin
                    retry_d = retry_q + RETRY_W'(1);
                end
            end

            DGRANT: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (!dreq) begin
                    state_d = IDLE;
                    retry_d = '0;
                end else if (ram_done) begin
                    state_d = IDLE;
                    retry_d = '0;
                    // Streak only counts data grants that a waiting fetch had to sit through.
                    if (!iREN) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                    if (exhaust) begin
                        mem_err_d = 1'b1;
                    end
                end else if (ramstate == ERROR) begin
                    retry_d = retry_q + RETRY_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            streak_q  <= '0;
            retry_q   <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            streak_q  <= streak_d;
            retry_q   <= retry_d;
            mem_err_q <= mem_err_d;
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single-ported unified RAM between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the 5-stage pipeline.
- Drives iwait/dwait back to the pipeline; the hazard unit consumes these as the fetch-stall and dhit sources.
- Registered-grant FSM with data priority, a starvation guard for fetch, and bounded retry on RAM error.

Parameters:
- MAX_DSTREAK, 4, consecutive data grants allowed while a fetch is pending before fetch is forced next.
- MAX_RETRY, 3, RAM ERROR retries per transaction before the sticky error flag sets.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- iREN  in  1  instruction read request, held until iwait low
- iaddr  in  32  instruction word address
- iload  out  32  fetched instruction
- iwait  out  1  high while instruction request is not complete
- dREN  in  1  data read request
- dWEN  in  1  data write request (dREN and dWEN are never both high)
- daddr  in  32  data address
- dstore  in  32  write data
- dload  out  32  read data
- dwait  out  1  high while data request is not complete
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- mem_err  out  1  sticky; set when MAX_RETRY is exhausted

Behaviour:
- Interface decision: one clock CLK; reset RST is synchronous and active-high.
- States: IDLE, IGRANT, DGRANT.
- Reset: state IDLE, streak 0, retry 0, mem_err 0; all ram* outputs 0.
- iwait and dwait are combinational: high whenever the matching request is asserted, except in the completion cycle.
- iload = dload = ramload (combinational); only valid in the completion cycle.
- IDLE arbitration:
  - Data request and streak < MAX_DSTREAK: go DGRANT.
  - Otherwise, iREN: go IGRANT.
  - Data request with streak == MAX_DSTREAK and iREN high: go IGRANT.
  - No request: stay IDLE.
  - The grant is registered. The RAM sees controls from the first grant cycle onward, so minimum latency is 2 cycles (request cycle + ACCESS cycle).
- Streak counter:
  - Increments on each data completion while iREN is high.
  - Clears on instruction completion, or when iREN is low at a data completion.
  - Saturates at MAX_DSTREAK.
- In a grant state:
  - ram* outputs reflect the granted requester's live inputs (addr, store, REN/WEN).
  - Other requester's port: ram* outputs are 0.
  - ramstate ACCESS: completion cycle. The granted wait output drops for exactly this cycle; retry clears; next state is IDLE.
  - ramstate FREE or BUSY: hold the grant.
  - ramstate ERROR, retry < MAX_RETRY: retry++, hold the grant (the RAM re-attempts).
  - ramstate ERROR, retry == MAX_RETRY: set mem_err, complete as if ACCESS (wait drops, data undefined), retry clears.
- Abort: in IGRANT with iREN low (pipeline flush), go IDLE next cycle, no completion, retry cleared. Data requests are never withdrawn. A dREN/dWEN drop in DGRANT is treated identically (defensive).
- Back-to-back: after completion the FSM returns through IDLE. No bubble-free chaining; each access costs ≥2 cycles.
- Reset mid-transaction: RST in any state returns to IDLE at the next edge. ram* outputs are 0 in the following cycle. mem_err clears.
- Arithmetic: streak is a $clog2(MAX_DSTREAK+1)-bit counter and retry a $clog2(MAX_RETRY+1)-bit counter; neither wraps.

Decomposition:
- cpu_types_pkg holds ramstate_t, word_t and a new arb_state_t enum (IDLE, IGRANT, DGRANT).
- Single module, no sub-module. The FSM, counters and output mux are small enough to keep together.

Test Plan:
- Solo fetch: iREN=1, iaddr=0x40, RAM returns ACCESS on the 2nd grant cycle with ramload=0x8C010004 -> iwait low for exactly one cycle, iload=0x8C010004, ramREN=1, ramaddr=0x40 during the grant.
- Simultaneous requests: iREN=1 and dWEN=1 (daddr=0x100, dstore=0xDEAD) in the same cycle -> DGRANT first with ramWEN=1, ramstore=0xDEAD; IGRANT after dwait drops.
- Starvation guard: iREN held while 5 data reads arrive back-to-back, MAX_DSTREAK=4 -> exactly 4 data completions, then the instruction completes, then the 5th data read.
- Flush abort: in IGRANT with ramstate BUSY, drop iREN -> IDLE next cycle, ramREN=0, no iwait low pulse, then a subsequent dREN is served normally.
- Error retry: ramstate=ERROR for 3 cycles then ACCESS, MAX_RETRY=3 -> completes normally, mem_err=0. Repeat with 4 ERRORs -> mem_err=1 with dwait dropping on the 4th ERROR; mem_err stays set until RST.
- Reset mid-access: assert RST during DGRANT -> next cycle IDLE, all ram* 0, mem_err 0, streak 0.
